// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: scans NUM_SYN stored weights against one
// timestep of presynaptic spikes, leaks, then fires with a refractory holdoff.
module lif_spike_generator #(
  parameter int NUM_SYN    = 16,
  parameter int W_WIDTH    = 4,
  parameter int V_WIDTH    = 8,
  parameter int THRESHOLD  = 20,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2,
  localparam int AW        = $clog2(NUM_SYN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               step_valid,
  input  logic [NUM_SYN-1:0] pre_spikes,
  output logic               step_ready,
  output logic               weight_rd,
  output logic [AW-1:0]      weight_addr,
  input  logic [W_WIDTH-1:0] weight_data,
  output logic               post_spike,
  output logic               step_done,
  output logic [V_WIDTH-1:0] membrane,
  output logic               refractory
);
  localparam int KW = $clog2(NUM_SYN + 1);
  localparam int CW = $clog2(REFRACT + 1);
  localparam logic [V_WIDTH:0] TH = (V_WIDTH+1)'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, SCAN, LEAK, EVAL} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [NUM_SYN-1:0] pre_q, pre_d;
  logic [V_WIDTH-1:0] mem_q, mem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               post_q, post_d;
  logic               done_q, done_d;

  logic [V_WIDTH:0]   sum;
  logic [V_WIDTH-1:0] sat;

  assign weight_rd   = (state_q == SCAN) && (k_q < KW'(NUM_SYN));
  assign weight_addr = weight_rd ? AW'(k_q) : addr_q;
  assign step_ready  = (state_q == IDLE);
  assign post_spike  = post_q;
  assign step_done   = done_q;
  assign membrane    = mem_q;
  assign refractory  = (cnt_q != '0);

  // Weight for synapse k-1 arrives in scan cycle k; clamp instead of wrapping.
  assign sum = {1'b0, mem_q} + {{(V_WIDTH+1-W_WIDTH){1'b0}}, weight_data};
  assign sat = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pre_d   = pre_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    addr_d  = weight_rd ? AW'(k_q) : addr_q;
    post_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_valid) begin
          pre_d   = pre_spikes;
          k_d     = '0;
          state_d = (cnt_q == '0) ? SCAN : LEAK;
        end
      end
      SCAN: begin
        if (k_q != '0 && pre_q[AW'(k_q - 1'b1)]) mem_d = sat;
        if (k_q == KW'(NUM_SYN)) state_d = LEAK;
        else                     k_d     = k_q + 1'b1;
      end
      LEAK: begin
        mem_d   = mem_q - (mem_q >> LEAK_SHIFT);
        state_d = EVAL;
      end
      EVAL: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ({1'b0, mem_q} >= TH) begin
          post_d = 1'b1;
          mem_d  = '0;
          cnt_d  = CW'(REFRACT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      pre_q   <= '0;
      mem_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      post_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pre_q   <= pre_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      post_q  <= post_d;
      done_q  <= done_d;
    end
  end
endmodule
